// File: rtl/mul_seq_pkg.sv
// Shared processor package: datapath width, ALU control codes and the
// state type used by the sequential multiplier.
package mul_seq_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Request/result handshake bundle of the sequential multiplier.
// The slave side is the multiplier, the master side is its user.
interface mul_seq_if;
    import mul_seq_pkg::*;

    logic              i_valid;
    logic [DATA_W-1:0] i_a;
    logic [DATA_W-1:0] i_b;
    logic              i_flush;
    logic              i_ready;
    logic              o_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_result;
    logic              o_busy;

    modport slave (
        input  i_valid, i_a, i_b, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_busy
    );

    modport master (
        output i_valid, i_a, i_b, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_busy
    );

endinterface

// File: rtl/mul_seq_alu.sv
// Small combinational processor ALU. Results wrap modulo 2^DATA_W; no
// carry-out is produced.
module alu
    import mul_seq_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_ctrl_e         i_ctrl,
    output logic [DATA_W-1:0] o_y,
    output logic              o_zero
);

    // Select the operation requested by the control code
    always_comb begin
        o_y = '0;
        case (i_ctrl)
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            ALU_SLT: o_y = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLL: o_y = i_a << i_b[4:0];
            ALU_SRL: o_y = i_a >> i_b[4:0];
            default: o_y = '0;
        endcase
    end

    assign o_zero = (o_y == '0);

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier. Returns the low 32 bits of a*b,
// spending one cycle per significant bit of the multiplier.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    mul_seq_if.slave  bus
);

    state_e            r_state;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic              r_ready;
    logic              r_valid;
    logic              r_busy;
    logic [DATA_W-1:0] r_result;

    logic [DATA_W-1:0] w_aluY;
    logic              w_unusedZero;
    logic [DATA_W-1:0] w_accNext;
    logic [DATA_W-1:0] w_mplierNext;

    alu u_alu (
        .i_a    (r_acc),
        .i_b    (r_mcand),
        .i_ctrl (ALU_ADD),
        .o_y    (w_aluY),
        .o_zero (w_unusedZero)
    );

    assign w_accNext    = r_mplier[0] ? w_aluY : r_acc;
    assign w_mplierNext = r_mplier >> 1;

    // Control FSM and datapath registers; outputs are registered alongside the state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
        end else if (bus.i_flush) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_mcand  <= bus.i_a;
                        r_mplier <= bus.i_b;
                        r_acc    <= '0;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                        if (bus.i_b == '0) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplierNext;
                    if (w_mplierNext == '0) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                        r_result <= w_accNext;
                    end
                end
                S_DONE: begin
                    if (bus.i_ready) begin
                        r_state  <= S_IDLE;
                        r_valid  <= 1'b0;
                        r_ready  <= 1'b1;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ready  <= 1'b1;
                    r_valid  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_result <= '0;
                end
            endcase
        end
    end

    assign bus.o_ready  = r_ready;
    assign bus.o_valid  = r_valid;
    assign bus.o_busy   = r_busy;
    assign bus.o_result = r_result;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for the sequential multiplier.
module tb_mul_seq;
    import mul_seq_pkg::*;

    logic i_clk;
    logic i_rst;
    int   checks;
    int   failures;

    mul_seq_if bus ();

    mul_seq dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one request for a single accepting edge, then change the operands
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        bus.i_valid = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        step();
        bus.i_valid = 1'b0;
        bus.i_a     = ~a;
        bus.i_b     = ~b;
    endtask

    // Number of further edges until o_valid is seen, or -1 if it never comes
    task automatic wait_valid(input int bound, output int edges);
        edges = 0;
        while (!bus.o_valid && edges < bound) begin
            step();
            edges++;
        end
        if (!bus.o_valid) edges = -1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        #12;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=100", {bus.o_ready, bus.o_valid, bus.o_busy});
        end
        checks++;
        if (bus.o_result !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_result got=%h exp=00000000", bus.o_result);
        end
        #2;
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int edges;
        applyStimulus(32'd3, 32'd5);
        checks++;
        if ({bus.o_ready, bus.o_busy} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL basic_run_flags got=%b exp=01", {bus.o_ready, bus.o_busy});
        end
        wait_valid(40, edges);
        checks++;
        if (edges !== 3) begin
            failures++;
            $display("[TB] FAIL basic_latency got=%0d exp=3", edges);
        end
        checks++;
        if (bus.o_result !== 32'd15) begin
            failures++;
            $display("[TB] FAIL basic_result got=%0d exp=15", bus.o_result);
        end
        step();
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_result} !== {2'b10, 32'h0}) begin
            failures++;
            $display("[TB] FAIL basic_handoff got=%b/%h exp=10/00000000", {bus.o_ready, bus.o_valid}, bus.o_result);
        end
    endtask

    task automatic test_zero();
        int edges;
        int busySeen;
        applyStimulus(32'h12345678, 32'h0);
        busySeen = bus.o_busy ? 1 : 0;
        wait_valid(40, edges);
        checks++;
        if (edges !== 0) begin
            failures++;
            $display("[TB] FAIL zero_latency got=%0d exp=0", edges);
        end
        checks++;
        if (bus.o_result !== 32'h0 || busySeen != 0) begin
            failures++;
            $display("[TB] FAIL zero_result got=%h busy=%0d exp=00000000 busy=0", bus.o_result, busySeen);
        end
        step();
    endtask

    task automatic test_max();
        int edges;
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_valid(40, edges);
        checks++;
        if (edges !== 32) begin
            failures++;
            $display("[TB] FAIL max_latency got=%0d exp=32", edges);
        end
        checks++;
        if (bus.o_result !== 32'h00000001) begin
            failures++;
            $display("[TB] FAIL max_result got=%h exp=00000001", bus.o_result);
        end
        step();
    endtask

    task automatic test_backpressure();
        int edges;
        bus.i_ready = 1'b0;
        applyStimulus(32'd7, 32'd9);
        wait_valid(40, edges);
        checks++;
        if (edges !== 4) begin
            failures++;
            $display("[TB] FAIL bp_latency got=%0d exp=4", edges);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({bus.o_valid, bus.o_ready, bus.o_result} !== {2'b10, 32'd63}) begin
                failures++;
                $display("[TB] FAIL bp_hold cycle=%0d got=%b/%0d exp=10/63", i, {bus.o_valid, bus.o_ready}, bus.o_result);
            end
        end
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_a = 32'd1;
        bus.i_b = 32'd1;
        step();
        bus.i_valid = 1'b0;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL bp_release got=%b exp=100", {bus.o_ready, bus.o_valid, bus.o_busy});
        end
    endtask

    task automatic test_flush();
        int edges;
        int validSeen;
        applyStimulus(32'd10, 32'h80);
        step();
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL flush_idle got=%b exp=100", {bus.o_ready, bus.o_valid, bus.o_busy});
        end
        validSeen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.o_valid) validSeen = 1;
        end
        checks++;
        if (validSeen !== 0) begin
            failures++;
            $display("[TB] FAIL flush_no_result got=%0d exp=0", validSeen);
        end
        applyStimulus(32'd2, 32'd3);
        wait_valid(40, edges);
        checks++;
        if (edges !== 2 || bus.o_result !== 32'd6) begin
            failures++;
            $display("[TB] FAIL flush_followup got=%0d/%0d exp=2/6", edges, bus.o_result);
        end
        step();
    endtask

    task automatic test_async_reset();
        int edges;
        int validSeen;
        applyStimulus(32'd100, 32'hFF00);
        step();
        step();
        #3;
        i_rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_busy, bus.o_result} !== {3'b100, 32'h0}) begin
            failures++;
            $display("[TB] FAIL async_reset got=%b/%h exp=100/00000000", {bus.o_ready, bus.o_valid, bus.o_busy}, bus.o_result);
        end
        step();
        #3;
        i_rst = 1'b0;
        validSeen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.o_valid) validSeen = 1;
        end
        checks++;
        if (validSeen !== 0) begin
            failures++;
            $display("[TB] FAIL async_no_result got=%0d exp=0", validSeen);
        end
        #2;
        i_rst = 1'b1;
        #2;
        i_rst = 1'b0;
        applyStimulus(32'd4, 32'd4);
        wait_valid(40, edges);
        checks++;
        if (edges !== 3 || bus.o_result !== 32'd16) begin
            failures++;
            $display("[TB] FAIL post_reset_accept got=%0d/%0d exp=3/16", edges, bus.o_result);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port i_valid  input  1  request strobe; operands are accepted when i_valid & o_ready.
REQ-004 SHALL have port i_a  input  32  multiplicand, unsigned.
REQ-005 SHALL have port i_b  input  32  multiplier, unsigned.
REQ-006 SHALL have port i_flush  input  1  synchronous abort of any operation in progress.
REQ-007 SHALL have port o_ready  output  1  high only in IDLE.
REQ-008 SHALL have port o_valid  output  1  result available; high only in DONE.
REQ-009 SHALL have port o_result  output  32  low 32 bits of i_a*i_b; valid only while o_valid is high.
REQ-010 SHALL have port i_ready  input  1  consumer accepts the result when o_valid & i_ready.
REQ-011 SHALL have port o_busy  output  1  high in RUN.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE.
REQ-013 SHALL, on accept in IDLE, load mcand=i_a, mplier=i_b and acc=0; next state is DONE if i_b==0, else RUN.
REQ-014 SHALL perform one RUN iteration per cycle: if mplier[0], acc <= acc + mcand computed by the ALU with ADD control; mcand <<= 1 with bits shifted past bit 31 discarded; mplier >>= 1 logically.
REQ-015 SHALL leave RUN for DONE on the edge at which the shifted mplier becomes 0 (early termination).
REQ-016 SHALL assert o_valid exactly k edges after the accepting edge, where k = bit-length of i_b (0 for i_b==0, 32 for any i_b with bit 31 set).
REQ-017 SHALL compute all arithmetic modulo 2^32; the ALU carry-out is discarded.
REQ-018 SHALL hold o_result and o_valid stable in DONE until i_ready; on o_valid & i_ready, next state is IDLE.
REQ-019 SHALL NOT accept a new request in the same cycle as the result handoff; o_ready rises one cycle after the handoff.
REQ-020 SHALL, on i_flush in any state, go to IDLE on the next edge and discard acc; i_flush takes priority over accept and over result handoff in the same cycle.
REQ-021 SHALL ignore i_a and i_b outside the accept cycle; operand changes during RUN do not affect the result.
REQ-022 SHALL drive o_result = acc in DONE and 32'h0 in all other states.
REQ-023 SHALL drive the ALU control input to the constant ADD code at all times; the ALU zero flag is unused.

Reset
REQ-024 SHALL, while i_rst is high, immediately force state=IDLE, acc=0, mcand=0 and mplier=0, giving o_ready=1, o_valid=0, o_busy=0 and o_result=0.
REQ-025 SHALL treat reset during RUN or DONE as a silent abort; no result is delivered.
REQ-026 SHALL be able to accept a request on the first rising edge after i_rst deasserts.

Structure
REQ-027 SHALL take the ALU control encodings (ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, XOR=3'b100, SLT=3'b101, SLL=3'b110, SRL=3'b111) and the state enum type from the shared processor package.
REQ-028 SHALL instantiate exactly one sub-module, alu, as the adder; all shifting is done with local registers.
REQ-029 SHALL fit in roughly 150-250 lines of RTL with no other sub-modules.

Verification
REQ-030 SHALL cover: a=3, b=5 accepted at edge E0 -> o_valid high after E3, o_result=15.
REQ-031 SHALL cover: a=0x12345678, b=0 -> o_valid high after the accept edge, o_result=0, o_busy never high.
REQ-032 SHALL cover: a=0xFFFFFFFF, b=0xFFFFFFFF -> 32 RUN cycles, o_result=0x00000001.
REQ-033 SHALL cover: a=7, b=9 with i_ready held low for 5 cycles -> o_valid and o_result=63 stable throughout; o_ready=1 one cycle after i_ready rises.
REQ-034 SHALL cover: i_flush asserted during the 2nd RUN cycle of a=10, b=0x80 -> IDLE next edge, o_valid never asserted; a following a=2, b=3 request -> result 6.
REQ-035 SHALL cover: i_rst pulsed mid-RUN (asynchronously, between edges) -> outputs reach reset values immediately, no result delivered.
